// File: rtl/fp_div.sv
`default_nettype none
// fp_div: iterative radix-2 restoring IEEE-754 divider, one quotient bit per clock.
// Rounding is truncation unless FP_DIV_RNE_EN is defined (round-to-nearest-even).
module fp_div #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23,
  parameter int BIAS      = 127
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PRECISION-1:0] a_operand,
  input  logic [PRECISION-1:0] b_operand,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PRECISION-1:0] result,
  output logic                 div_by_zero
);

  localparam int EW = EXPONENT + 2;
  localparam int MW = FRACTION + 1;
  localparam int RW = FRACTION + 2;
  localparam int QW = FRACTION + 3;
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0]        ITER_LAST = CW'(QW - 1);
  localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXPONENT) - 1);
  localparam logic signed [EW-1:0] E_ZERO    = '0;
  localparam logic signed [EW-1:0] E_ONE     = EW'(1);
  localparam logic signed [EW-1:0] E_BIAS    = EW'(BIAS);
  localparam logic [PRECISION-1:0] QNAN      =
    {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIV    = 3'd2,
    NORM   = 3'd3,
    PACK   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                 state;
  logic [PRECISION-1:0]   a_q, b_q;
  logic                   sign_q;
  logic signed [EW-1:0]   e_q;
  logic [RW-1:0]          rem_q;
  logic [MW-1:0]          div_q;
  logic [QW-1:0]          q_q;
  logic [CW-1:0]          cnt_q;
  logic                   is_special;
  logic [PRECISION-1:0]   spec_res_q;
  logic                   spec_dbz_q;

  // Operand fields
  logic                   sa, sb;
  logic [EXPONENT-1:0]    ea, eb;
  logic [FRACTION-1:0]    fa, fb;
  assign {sa, ea, fa} = a_q;
  assign {sb, eb, fb} = b_q;

  // Exponent zero is treated as zero: subnormals are flushed.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_w;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign sign_w = sa ^ sb;

  logic                 special;
  logic [PRECISION-1:0] spec_res;
  logic                 spec_dbz;

  always_comb begin
    special  = 1'b1;
    spec_res = QNAN;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
    end else if (a_inf) begin
      spec_res = {sign_w, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    end else if (b_inf) begin
      spec_res = {sign_w, {(PRECISION-1){1'b0}}};
    end else if (b_zero) begin
      spec_res = {sign_w, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      spec_dbz = 1'b1;
    end else if (a_zero) begin
      spec_res = {sign_w, {(PRECISION-1){1'b0}}};
    end else begin
      special  = 1'b0;
    end
  end

  // One restoring step
  logic          rem_ge;
  logic [RW-1:0] rem_diff, rem_next;
  assign rem_ge   = (rem_q >= {1'b0, div_q});
  assign rem_diff = rem_q - {1'b0, div_q};
  assign rem_next = rem_ge ? {rem_diff[RW-2:0], 1'b0} : {rem_q[RW-2:0], 1'b0};

`ifdef FP_DIV_RNE_EN
  logic sticky_q;
`else
  logic unused_lsbs;
  assign unused_lsbs = ^q_q[1:0];
`endif

  // Result packing from the normalised quotient (leading one at q_q[QW-1]).
  logic [FRACTION-1:0]  frac_t;
  logic                 round_up;
  logic [FRACTION:0]    frac_sum;
  logic signed [EW-1:0] e_fin;
  logic [PRECISION-1:0] pack_res;

  always_comb begin
    frac_t   = q_q[QW-2 -: FRACTION];
`ifdef FP_DIV_RNE_EN
    round_up = q_q[1] & (q_q[0] | sticky_q | frac_t[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, frac_t} + {{FRACTION{1'b0}}, round_up};
    e_fin    = frac_sum[FRACTION] ? (e_q + E_ONE) : e_q;
    if (e_fin >= E_MAX) begin
      pack_res = {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    end else if (e_fin <= E_ZERO) begin
      pack_res = {sign_q, {(PRECISION-1){1'b0}}};
    end else begin
      pack_res = {sign_q, e_fin[EXPONENT-1:0], frac_sum[FRACTION-1:0]};
    end
  end

  assign in_ready = reset_n && (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= 1'b0;
      e_q         <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      is_special  <= 1'b0;
      spec_res_q  <= '0;
      spec_dbz_q  <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
`ifdef FP_DIV_RNE_EN
      sticky_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_operand;
            b_q   <= b_operand;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q     <= sign_w;
          e_q        <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;
          rem_q      <= {1'b0, 1'b1, fa};
          div_q      <= {1'b1, fb};
          q_q        <= '0;
          cnt_q      <= ITER_LAST;
          is_special <= special;
          spec_res_q <= spec_res;
          spec_dbz_q <= spec_dbz;
          state      <= special ? PACK : DIV;
        end
        DIV: begin
          rem_q <= rem_next;
          q_q   <= {q_q[QW-2:0], rem_ge};
          if (cnt_q == '0) begin
            state <= NORM;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        NORM: begin
          // Quotient lies in (0.5, 2): at most one left shift is needed.
          if (!q_q[QW-1]) begin
            q_q <= {q_q[QW-2:0], 1'b0};
            e_q <= e_q - E_ONE;
          end
`ifdef FP_DIV_RNE_EN
          sticky_q <= (rem_q != '0);
`endif
          state <= PACK;
        end
        PACK: begin
          result      <= is_special ? spec_res_q : pack_res;
          div_by_zero <= is_special & spec_dbz_q;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_div.sv
`default_nettype none
// tb_fp_div: scoreboard bench for fp_div covering values, latency, specials,
// backpressure and asynchronous reset during an operation.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic        in_ready, out_valid, div_by_zero;
  logic [31:0] result;

  fp_div dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_operand   (a_operand),
    .b_operand   (b_operand),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   first_valid = -1;

`ifdef FP_DIV_RNE_EN
  localparam logic [31:0] THIRD    = 32'h3EAAAAAB;
  localparam logic [31:0] TWOTHIRD = 32'h3F2AAAAB;
`else
  localparam logic [31:0] THIRD    = 32'h3EAAAAAA;
  localparam logic [31:0] TWOTHIRD = 32'h3F2AAAAA;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: compare against the scoreboard on each accepted result.
  always @(negedge clk) begin
    if (!reset_n) begin
      first_valid = -1;
    end else if (out_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("result", result, mon_e.res);
          check("div_by_zero", div_by_zero, mon_e.dbz);
          check("latency", first_valid - mon_e.acc, mon_e.lat);
        end
        first_valid = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic dbz, input int lat);
    exp_t e;
    check("in_ready_before_send", in_ready, 1);
    a_operand = a;
    b_operand = b;
    in_valid  = 1'b1;
    e.res = res; e.dbz = dbz; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("drain_timeout", 1, 0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic dbz, input int lat);
    send(a, b, res, dbz, lat);
    drain();
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("out_valid_timeout", 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);
    tick();

    // Normal operands
    run(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29);
    run(32'h3F800000, 32'h40400000, THIRD,        1'b0, 29);
    run(32'h40000000, 32'h40400000, TWOTHIRD,     1'b0, 29);
    run(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 29);
    run(32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0, 29);
    run(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 1'b0, 29);
    run(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 29);
    run(32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 29);
    // Special cases
    run(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);
    run(32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 2);
    run(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 2);
    run(32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 2);
    run(32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 2);
    run(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 2);
    run(32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 2);
    run(32'h00000000, 32'h7F800000, 32'h00000000, 1'b0, 2);
    run(32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 2);
    run(32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 2);

    // Backpressure: result held, busy, stray operands ignored
    out_ready = 1'b0;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      check("bp_result", result, 32'h40400000);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      a_operand = 32'h3F800000;
      b_operand = 32'h00000000;
      in_valid  = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);
    run(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 29);

    // Reset during DIV
    send(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29);
    repeat (11) tick();
    reset_n = 1'b0;
    #1;
    check("rst_div_out_valid", out_valid, 0);
    check("rst_div_result", result, 0);
    check("rst_div_in_ready", in_ready, 0);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    run(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29);

    // Reset while a result is held
    out_ready = 1'b0;
    send(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 2);
    wait_out_valid();
    check("hold_dbz", div_by_zero, 1);
    reset_n = 1'b0;
    #1;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_result", result, 0);
    check("rst_done_dbz", div_by_zero, 0);
    sb.delete();
    out_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    run(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
